// File: rtl/irda_tx_mode_ctrl_pkg.sv
// Shared mode/state encodings and a small helper for the IrDA TX mode controller.
package irda_tx_mode_ctrl_pkg;

    localparam logic [1:0] IRDA_MODE_SIR  = 2'b00;
    localparam logic [1:0] IRDA_MODE_MIR  = 2'b01;
    localparam logic [1:0] IRDA_MODE_FIR  = 2'b10;
    localparam logic [1:0] IRDA_MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_GUARD  = 2'b11
    } irda_state_t;

    // Busy flag of the encoder that belongs to a given mode; reserved mode is never busy.
    function automatic logic mode_busy(input logic [1:0] mode,
                                       input logic sir_busy,
                                       input logic mir_busy,
                                       input logic fir_busy);
        logic b;
        b = 1'b0;
        case (mode)
            IRDA_MODE_SIR: b = sir_busy;
            IRDA_MODE_MIR: b = mir_busy;
            IRDA_MODE_FIR: b = fir_busy;
            default:       b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/irda_tx_mode_ctrl_sip_sched.sv
// SIP scheduler: free-running period down-counter plus a pending flag.
// 'run' and 'busy' describe the cycle that follows the current edge, so
// sip_start is registered yet can fire on the very first ACTIVE cycle.
module irda_tx_mode_ctrl_sip_sched #(
    parameter int SIP_PERIOD = 20000000,
    parameter int CNT_W      = 25
) (
    input  logic clk,
    input  logic wb_rst_i,
    input  logic run,
    input  logic busy,
    input  logic sip_busy,
    output logic sip_start
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SIP_PERIOD - 1);

    logic [CNT_W-1:0] period_cnt;
    logic             sip_pending;
    logic             run_q;
    logic             run_rise;
    logic             period_due;
    logic             pending_eff;
    logic             fire;

    assign run_rise    = run && !run_q;
    assign period_due  = run && run_q && (period_cnt == '0);
    assign pending_eff = sip_pending || run_rise || period_due;
    assign fire        = run && pending_eff && !busy && !sip_busy;

    // Period counter keeps its grid regardless of deferred pulses; pending holds a deferred SIP.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            period_cnt  <= '0;
            sip_pending <= 1'b0;
            run_q       <= 1'b0;
            sip_start   <= 1'b0;
        end else begin
            run_q       <= run;
            sip_start   <= fire;
            sip_pending <= run && pending_eff && !fire;
            if (!run || run_rise || period_cnt == '0)
                period_cnt <= RELOAD;
            else
                period_cnt <= period_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/irda_tx_mode_ctrl.sv
// IrDA TX mode controller: owns the output mux select/mode and encoder enables,
// switches modes only after draining the active encoder and a deselected guard.
//   state  | meaning
//   OFF    | transmitter idle, output deselected
//   ACTIVE | cur_mode encoder enabled, output selected
//   DRAIN  | enables dropped, waiting for encoder and SIP to go idle
//   GUARD  | output deselected for GUARD_CYCLES before applying the new mode
module irda_tx_mode_ctrl
    import irda_tx_mode_ctrl_pkg::*;
#(
    parameter int GUARD_CYCLES = 16,
    parameter int SIP_PERIOD   = 20000000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic       tx_enable,
    input  logic [1:0] req_mode,
    input  logic       sip_en,
    input  logic       sir_busy,
    input  logic       mir_busy,
    input  logic       fir_busy,
    input  logic       sip_busy,
    output logic       tx_select,
    output logic       fast_mode,
    output logic       mir_mode,
    output logic       sir_en,
    output logic       mir_en,
    output logic       fir_en,
    output logic       sip_start,
    output logic [1:0] cur_mode,
    output logic       switching
);

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    irda_state_t      state;
    irda_state_t      state_nxt;
    logic [1:0]       mode_nxt;
    logic [CNT_W-1:0] guard_cnt;
    logic             req_ok;
    logic             cur_busy;
    logic             nxt_busy;
    logic             run_nxt;

    assign req_ok   = (req_mode != IRDA_MODE_RSVD);
    assign cur_busy = mode_busy(cur_mode, sir_busy, mir_busy, fir_busy);
    assign nxt_busy = mode_busy(mode_nxt, sir_busy, mir_busy, fir_busy);
    assign run_nxt  = (state_nxt == ST_ACTIVE) && (mode_nxt != IRDA_MODE_SIR) && sip_en;

    // Next state and next applied mode; outputs are registered from these.
    always_comb begin
        state_nxt = state;
        mode_nxt  = cur_mode;
        case (state)
            ST_OFF: begin
                if (tx_enable && req_ok) begin
                    state_nxt = ST_ACTIVE;
                    mode_nxt  = req_mode;
                end
            end
            ST_ACTIVE: begin
                if (!tx_enable || (req_ok && req_mode != cur_mode))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!cur_busy && !sip_busy)
                    state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_cnt == '0) begin
                    if (!tx_enable) begin
                        state_nxt = ST_OFF;
                    end else begin
                        state_nxt = ST_ACTIVE;
                        if (req_ok)
                            mode_nxt = req_mode;
                    end
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // State, guard timer and all mode-dependent outputs, registered together.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_OFF;
            cur_mode  <= IRDA_MODE_SIR;
            guard_cnt <= '0;
            tx_select <= 1'b0;
            fast_mode <= 1'b0;
            mir_mode  <= 1'b0;
            sir_en    <= 1'b0;
            mir_en    <= 1'b0;
            fir_en    <= 1'b0;
            switching <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_mode <= mode_nxt;
            if (state == ST_DRAIN && state_nxt == ST_GUARD)
                guard_cnt <= GUARD_LOAD;
            else if (state == ST_GUARD && guard_cnt != '0)
                guard_cnt <= guard_cnt - 1'b1;
            tx_select <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_DRAIN);
            switching <= (state_nxt == ST_DRAIN) || (state_nxt == ST_GUARD);
            fast_mode <= (mode_nxt != IRDA_MODE_SIR);
            mir_mode  <= (mode_nxt == IRDA_MODE_MIR);
            sir_en    <= (state_nxt == ST_ACTIVE) && (mode_nxt == IRDA_MODE_SIR);
            mir_en    <= (state_nxt == ST_ACTIVE) && (mode_nxt == IRDA_MODE_MIR);
            fir_en    <= (state_nxt == ST_ACTIVE) && (mode_nxt == IRDA_MODE_FIR);
        end
    end

    irda_tx_mode_ctrl_sip_sched #(
        .SIP_PERIOD (SIP_PERIOD),
        .CNT_W      (CNT_W)
    ) u_sip_sched (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .run       (run_nxt),
        .busy      (nxt_busy),
        .sip_busy  (sip_busy),
        .sip_start (sip_start)
    );

endmodule

// File: tb/tb_irda_tx_mode_ctrl.sv
// Directed bench for irda_tx_mode_ctrl with GUARD_CYCLES=4, SIP_PERIOD=10.
module tb_irda_tx_mode_ctrl;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       tx_enable = 1'b0;
    logic [1:0] req_mode = 2'b00;
    logic       sip_en = 1'b1;
    logic       sir_busy = 1'b0;
    logic       mir_busy = 1'b0;
    logic       fir_busy = 1'b0;
    logic       sip_busy = 1'b0;
    logic       tx_select, fast_mode, mir_mode, sir_en, mir_en, fir_en, sip_start, switching;
    logic [1:0] cur_mode;

    int checks = 0;
    int failures = 0;
    int n;
    int pulses;

    irda_tx_mode_ctrl #(.GUARD_CYCLES(4), .SIP_PERIOD(10), .CNT_W(25)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .tx_enable(tx_enable), .req_mode(req_mode),
        .sip_en(sip_en), .sir_busy(sir_busy), .mir_busy(mir_busy), .fir_busy(fir_busy),
        .sip_busy(sip_busy), .tx_select(tx_select), .fast_mode(fast_mode), .mir_mode(mir_mode),
        .sir_en(sir_en), .mir_en(mir_en), .fir_en(fir_en), .sip_start(sip_start),
        .cur_mode(cur_mode), .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count cycles until tx_select returns to 1 (bounded).
    task automatic count_guard(output int cnt);
        cnt = 0;
        while (tx_select == 1'b0 && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    // Count cycles until the next sip_start (bounded).
    task automatic wait_sip(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (sip_start == 1'b0 && cnt < 40);
    endtask

    initial begin
        #1 wb_rst_i = 1'b1;
        @(negedge clk);
        chk("rst_tx_select", tx_select, 0);
        chk("rst_cur_mode", cur_mode, 0);
        chk("rst_enables", {sir_en, mir_en, fir_en, fast_mode, mir_mode}, 0);
        chk("rst_sip_switch", {sip_start, switching}, 0);
        wb_rst_i = 1'b0;
        tick();
        chk("off_idle", {tx_select, switching}, 0);

        // Enable in SIR
        tx_enable = 1'b1;
        req_mode  = 2'b00;
        tick();
        chk("sir_tx_select", tx_select, 1);
        chk("sir_en", sir_en, 1);
        chk("sir_fast", fast_mode, 0);
        chk("sir_cur_mode", cur_mode, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sip_start) pulses++;
        end
        chk("sir_no_sip", pulses, 0);

        // SIR -> FIR while SIR encoder busy
        sir_busy = 1'b1;
        req_mode = 2'b10;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx_select && !sir_en && switching) n++;
        end
        chk("drain_hold", n, 6);
        sir_busy = 1'b0;
        tick();
        count_guard(n);
        chk("guard_len", n, 4);
        chk("fir_cur_mode", cur_mode, 2);
        chk("fir_modes", {fast_mode, mir_mode, fir_en, sir_en, mir_en}, 5'b10100);
        chk("fir_first_sip", sip_start, 1);

        // Periodic SIP, then a deferred one
        wait_sip(n);
        chk("sip_period", n, 10);
        fir_busy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sip_start) pulses++;
        end
        chk("sip_held_by_busy", pulses, 0);
        fir_busy = 1'b0;
        tick();
        chk("sip_deferred", sip_start, 1);
        wait_sip(n);
        chk("sip_grid_kept", n, 7);

        // FIR -> request MIR, change to SIR during guard
        req_mode = 2'b01;
        tick();
        chk("fir_drain", {switching, tx_select, fir_en}, 3'b110);
        tick();
        chk("fir_guard", {switching, tx_select}, 2'b10);
        req_mode = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("latest_req_mode", cur_mode, 0);
        chk("latest_req_outs", {tx_select, sir_en, fast_mode, switching}, 4'b1100);

        // Request returning to the old mode still takes the full guard
        req_mode = 2'b01;
        tick();
        tick();
        req_mode = 2'b00;
        count_guard(n);
        chk("return_guard_len", n, 4);
        chk("return_cur_mode", cur_mode, 0);

        // Reserved request is ignored
        req_mode = 2'b11;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (switching || cur_mode != 2'b00 || !tx_select) n++;
        end
        chk("rsvd_ignored", n, 0);

        // SIR -> MIR, then disable
        req_mode = 2'b01;
        tick();
        tick();
        count_guard(n);
        chk("mir_guard_len", n, 4);
        chk("mir_modes", {cur_mode, mir_mode, mir_en, fast_mode, sip_start}, 6'b011111);
        tx_enable = 1'b0;
        tick();
        chk("off_drain", {switching, tx_select, mir_en}, 3'b110);
        tick();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (switching && !tx_select) n++;
            tick();
        end
        chk("off_guard_cycles", n, 4);
        chk("off_state", {tx_select, switching, mir_en, sip_start}, 0);
        chk("off_cur_mode", cur_mode, 1);

        // Reset during DRAIN
        tx_enable = 1'b1;
        tick();
        chk("reenable_mir", {tx_select, mir_en}, 2'b11);
        tx_enable = 1'b0;
        mir_busy  = 1'b1;
        tick();
        tick();
        chk("stuck_drain", {switching, tx_select}, 2'b11);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("async_rst_outs", {tx_select, fast_mode, mir_mode, sir_en, mir_en, fir_en, sip_start, switching}, 0);
        chk("async_rst_mode", cur_mode, 0);
        tick();
        wb_rst_i = 1'b0;
        mir_busy = 1'b0;
        tick();
        tick();
        chk("post_rst_off", {tx_select, switching, cur_mode}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irda_tx_mode_ctrl.md
Name: irda_tx_mode_ctrl

Overview:
- Sequences the IrDA transmit path: owns the select and mode controls of the sampled TX output mux and the SIR/MIR/FIR encoder enables.
- Applies software mode requests (SIR/MIR/FIR) only at safe points. The active encoder is drained, then a guard interval with the output deselected is inserted before the new mode is applied.
- Schedules Serial Infrared Interaction Pulses (SIP) while in MIR/FIR.
- Sits between the register file and the encoders plus output mux.

Parameters:
- GUARD_CYCLES, 16, clk cycles with tx_select=0 between modes (≥1).
- SIP_PERIOD, 20000000, clk cycles between SIP starts (500 ms at 40 MHz).
- CNT_W, 25, width of the SIP and guard counters; must hold SIP_PERIOD and GUARD_CYCLES.

Ports:
- clk  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- tx_enable  in  1  software transmit enable (level)
- req_mode  in  2  requested mode: 00 SIR, 01 MIR, 10 FIR, 11 reserved (ignored)
- sip_en  in  1  enable periodic SIP in fast modes
- sir_busy  in  1  SIR encoder transmitting
- mir_busy  in  1  MIR encoder transmitting
- fir_busy  in  1  FIR encoder transmitting
- sip_busy  in  1  SIP generator emitting a pulse
- tx_select  out  1  output mux sample enable
- fast_mode  out  1  1 = MIR or FIR
- mir_mode  out  1  1 = MIR
- sir_en  out  1  SIR encoder may start frames
- mir_en  out  1  MIR encoder may start frames
- fir_en  out  1  FIR encoder may start frames
- sip_start  out  1  one-cycle SIP trigger
- cur_mode  out  2  mode currently applied
- switching  out  1  1 in DRAIN or GUARD

Behaviour:
- One clock domain; reset is asynchronous and active-high on wb_rst_i. All outputs are registered.
- Reset values: state OFF, cur_mode=00, tx_select=0, fast_mode=0, mir_mode=0, sir_en=mir_en=fir_en=0, sip_start=0, switching=0, counters 0.
- Derived outputs:
  - fast_mode = (cur_mode!=00); mir_mode = (cur_mode==01).
  - tx_select=1 in ACTIVE and DRAIN only.
  - Encoder enable for cur_mode is 1 only in ACTIVE.
- State OFF:
  - tx_enable=1 and req_mode!=11 → load cur_mode=req_mode, go to ACTIVE.
  - tx_enable=1 with req_mode=11 → stay in OFF.
- State ACTIVE:
  - tx_enable=0 → DRAIN.
  - req_mode!=11 and req_mode!=cur_mode → DRAIN.
  - If both conditions hold, a single DRAIN is taken.
- State DRAIN:
  - Encoder enables=0; tx_select stays 1.
  - Leave to GUARD when busy of cur_mode's encoder=0 and sip_busy=0, both in the same cycle.
  - Other encoders' busy inputs are ignored.
- State GUARD:
  - tx_select=0; counter loaded with GUARD_CYCLES-1 on entry and counts down.
  - At 0: tx_enable=0 → OFF (cur_mode unchanged).
  - At 0: otherwise re-sample req_mode. If !=11 load it into cur_mode, else keep cur_mode; go to ACTIVE.
  - The latest request wins. A request that returns to the old mode still completes the full guard.
- Timing:
  - Mode-dependent outputs change on the GUARD→ACTIVE edge, together with tx_select=1.
  - Total switch latency = drain time + GUARD_CYCLES + 1 cycle.
- SIP scheduler, active only in ACTIVE with fast_mode=1 and sip_en=1:
  - On entry to ACTIVE (or when sip_en rises), sip_pending=1 and the counter is loaded with SIP_PERIOD-1.
  - The counter decrements each cycle; at 0 it sets sip_pending and reloads.
  - sip_start pulses for 1 cycle when sip_pending=1, the current encoder busy=0 and sip_busy=0. sip_pending then clears.
  - A deferred SIP does not delay the period counter.
  - Leaving ACTIVE, sip_en=0, or SIR mode clears sip_pending and holds the counter at reload.
- Reset asserted mid-operation returns to OFF immediately; outputs reach reset values asynchronously.

Decomposition:
- Shared include irda_defines.v: mode encodings (IRDA_MODE_SIR=2'b00, _MIR=2'b01, _FIR=2'b10, _RSVD=2'b11) and the state encodings OFF/ACTIVE/DRAIN/GUARD.
- One sub-module, irda_sip_sched: period counter, sip_pending and sip_start logic. Inputs: run, busy, sip_busy.

Test Plan (bench: GUARD_CYCLES=4, SIP_PERIOD=10):
- Reset, then tx_enable=1, req_mode=00 → next cycle: ACTIVE, tx_select=1, sir_en=1, fast_mode=0; sip_start never pulses.
- In SIR with sir_busy=1, set req_mode=10 for 6 cycles → tx_select stays 1 and sir_en=0; drop sir_busy → tx_select=0 for exactly 4 cycles; then cur_mode=10, fast_mode=1, mir_mode=0, fir_en=1, and sip_start pulses on the first ACTIVE cycle.
- FIR, sip_en=1, idle → sip_start every 10 cycles. Hold fir_busy=1 across a due point → pulse deferred to the cycle after busy falls; next pulse stays on the original 10-cycle grid.
- During GUARD, change req_mode 01→00 (cur_mode 00) → after guard, cur_mode=00; then set req_mode=11 → no transition.
- ACTIVE MIR, drop tx_enable with mir_busy=0 → DRAIN 1 cycle, GUARD 4 cycles, OFF with tx_select=0 and cur_mode=01.
- Assert wb_rst_i during DRAIN → all outputs 0 asynchronously; after release, state OFF.
